uart_rx_fifo: RTL and testbench

Serial UART receiver with 16x oversampling, start-bit validation, a show-ahead receive FIFO and sticky error flags. It is the receive end of the board's 8N1 serial link and takes the `RX` pad. It hands bytes to the 6502 system's peripheral bus logic through a valid/ready handshake. It mirrors the existing transmit path: same frame format, same baud divisor convention.

---
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, start-bit check, show-ahead FIFO and sticky error flags
//   clk, reset_n        : system clock, asynchronous active-low reset
//   rx                  : raw serial input, idle high, asynchronous to clk
//   rx_data, rx_valid   : FIFO head byte and not-empty, consumed by rx_ready
//   rx_count            : bytes held, 0..2^AW
//   overrun, frame_err  : sticky errors, cleared by an err_clr pulse (set wins)
module uart_rx_fifo #(
  parameter int DIV = 26,
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [AW:0] rx_count,
  output logic        overrun,
  output logic        frame_err,
  input  logic        err_clr
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t state, state_n;
  logic s1, rxs;
  logic [15:0] cnt;
  logic [3:0] sub, sub_n;
  logic [2:0] bitn, bitn_n;
  logic [7:0] sh, sh_n;
  logic tick, push, ferr_set, pop, push_ok;
  logic [7:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign tick = cnt == 16'(DIV - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {rx, s1};
  always_comb begin
    state_n = state;
    sub_n = tick ? sub + 4'd1 : sub;
    bitn_n = bitn;
    sh_n = sh;
    push = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        sub_n = 4'd0;
      end
      START: if (tick && sub == 4'd7) begin
        state_n = rxs ? IDLE : DATA;
        sub_n = 4'd0;
        bitn_n = 3'd0;
      end
      DATA: if (tick && sub == 4'd15) begin
        sh_n = {rxs, sh[7:1]};
        bitn_n = bitn + 3'd1;
        state_n = bitn == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick && sub == 4'd15) begin
        push = rxs;
        ferr_set = !rxs;
        state_n = rxs ? IDLE : WAIT_HI;
      end
      WAIT_HI: state_n = rxs ? IDLE : WAIT_HI;
      default: state_n = IDLE;
    endcase
  end
  // The divider is parked at 0 in IDLE so bit phase is measured from the detected start edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      sub <= '0;
      bitn <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || tick) ? 16'd0 : cnt + 16'd1;
      sub <= sub_n;
      bitn <= bitn_n;
      sh <= sh_n;
    end
  assign rx_valid = rx_count != '0;
  assign pop = rx_valid && rx_ready;
  // Full is count == 2^AW, i.e. the count MSB; a same-cycle pop frees the slot.
  assign push_ok = push && (!rx_count[AW] || pop);
  assign rx_data = rx_valid ? mem[rd_ptr] : 8'd0;
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= sh;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_count <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      rx_count <= rx_count + (AW+1)'(push_ok) - (AW+1)'(pop);
      overrun <= (push && !push_ok) || (overrun && !err_clr);
      frame_err <= ferr_set || (frame_err && !err_clr);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DIV=4, AW=4, 64 clk per bit)
module tb_uart_rx_fifo;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset_n, rx, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic rx_valid, overrun, frame_err;
  logic [AW:0] rx_count;
  int vec = 0;
  int errs = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.DIV(4), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_count(rx_count), .overrun(overrun), .frame_err(frame_err),
    .err_clr(err_clr)
  );
  // One 8N1 frame, 640 clk; rx_ready/err_clr pulse for one cycle at iteration rdy_at/clr_at.
  // lat = first iteration after which rx_count differs from its value at frame start.
  task automatic send(input logic [7:0] b, input logic stop, input int rdy_at, input int clr_at, output int lat);
    logic [9:0] f;
    logic [AW:0] c0;
    f = {stop, b, 1'b0};
    c0 = rx_count;
    lat = -1;
    for (int i = 0; i < 640; i++) begin
      rx = f[i/64];
      rx_ready = (i == rdy_at);
      err_clr = (i == clr_at);
      @(negedge clk);
      if (lat < 0 && rx_count !== c0) lat = i;
    end
    rx_ready = 1'b0;
    err_clr = 1'b0;
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_ready;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  task automatic pulse_clr;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask
  task automatic test_reset;
    reset_n = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    err_clr = 1'b0;
    wait_clk(3);
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    vec++; if (rx_count !== 5'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", rx_count); end
    vec++; if (rx_data !== 8'h00) begin errs++; $display("FAIL reset_data got %h exp 00", rx_data); end
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    reset_n = 1'b1;
    wait_clk(5);
  endtask
  task automatic test_basic;
    int lat;
    send(8'hA5, 1'b1, -1, -1, lat);
    vec++; if (lat < 605 || lat > 615) begin errs++; $display("FAIL basic_latency got %0d exp 605..615", lat); end
    vec++; if (rx_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got %b exp 1", rx_valid); end
    vec++; if (rx_data !== 8'hA5) begin errs++; $display("FAIL basic_data got %h exp a5", rx_data); end
    vec++; if (rx_count !== 5'd1) begin errs++; $display("FAIL basic_count got %0d exp 1", rx_count); end
    vec++; if ({overrun, frame_err} !== 2'b00) begin errs++; $display("FAIL basic_flags got %b exp 00", {overrun, frame_err}); end
    pulse_ready;
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL basic_pop_valid got %b exp 0", rx_valid); end
    vec++; if (rx_count !== 5'd0) begin errs++; $display("FAIL basic_pop_count got %0d exp 0", rx_count); end
  endtask
  task automatic test_burst_overrun;
    int lat;
    for (int i = 0; i < 17; i++) send(8'(i), 1'b1, -1, -1, lat);
    vec++; if (rx_count !== 5'd16) begin errs++; $display("FAIL burst_count got %0d exp 16", rx_count); end
    vec++; if (overrun !== 1'b1) begin errs++; $display("FAIL burst_overrun got %b exp 1", overrun); end
    for (int i = 0; i < 16; i++) begin
      vec++; if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin errs++; $display("FAIL burst_drain[%0d] got %b/%h exp 1/%h", i, rx_valid, rx_data, 8'(i)); end
      pulse_ready;
    end
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL burst_empty got %b exp 0", rx_valid); end
  endtask
  task automatic test_err_clr;
    pulse_clr;
    vec++; if ({overrun, frame_err} !== 2'b00) begin errs++; $display("FAIL clr_flags got %b exp 00", {overrun, frame_err}); end
  endtask
  task automatic test_glitch;
    int lat;
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    wait_clk(700);
    vec++; if (rx_count !== 5'd0) begin errs++; $display("FAIL glitch_count got %0d exp 0", rx_count); end
    vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL glitch_frame_err got %b exp 0", frame_err); end
    send(8'h5A, 1'b1, -1, -1, lat);
    vec++; if (rx_count !== 5'd1 || rx_data !== 8'h5A) begin errs++; $display("FAIL glitch_next got %0d/%h exp 1/5a", rx_count, rx_data); end
    pulse_ready;
  endtask
  task automatic test_frame_err;
    int lat;
    send(8'h3C, 1'b0, -1, -1, lat);
    rx = 1'b1;
    wait_clk(10);
    vec++; if (frame_err !== 1'b1) begin errs++; $display("FAIL frame_err got %b exp 1", frame_err); end
    vec++; if (rx_count !== 5'd0) begin errs++; $display("FAIL frame_count got %0d exp 0", rx_count); end
    pulse_clr;
    vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL frame_clr got %b exp 0", frame_err); end
  endtask
  task automatic test_break;
    rx = 1'b0;
    for (int i = 0; i < 3200; i++) begin
      err_clr = (i == 1000);
      @(negedge clk);
      if (i == 999) begin
        vec++; if (frame_err !== 1'b1) begin errs++; $display("FAIL break_first got %b exp 1", frame_err); end
      end
    end
    err_clr = 1'b0;
    rx = 1'b1;
    wait_clk(700);
    vec++; if (frame_err !== 1'b0) begin errs++; $display("FAIL break_single got %b exp 0", frame_err); end
    vec++; if (rx_count !== 5'd0) begin errs++; $display("FAIL break_count got %0d exp 0", rx_count); end
  endtask
  task automatic test_full_pop_collision;
    int lat;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b1, -1, -1, lat);
    vec++; if (rx_count !== 5'd16) begin errs++; $display("FAIL full_count got %0d exp 16", rx_count); end
    send(8'h99, 1'b1, 610, -1, lat);
    vec++; if (rx_count !== 5'd16) begin errs++; $display("FAIL fullpop_count got %0d exp 16", rx_count); end
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL fullpop_overrun got %b exp 0", overrun); end
    vec++; if (rx_data !== 8'h41) begin errs++; $display("FAIL fullpop_head got %h exp 41", rx_data); end
    send(8'h77, 1'b1, -1, 610, lat);
    vec++; if (overrun !== 1'b1) begin errs++; $display("FAIL collide_overrun got %b exp 1", overrun); end
    vec++; if (rx_count !== 5'd16) begin errs++; $display("FAIL collide_count got %0d exp 16", rx_count); end
    pulse_clr;
    vec++; if (overrun !== 1'b0) begin errs++; $display("FAIL collide_clr got %b exp 0", overrun); end
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 8'h99 : 8'h41 + 8'(i);
      vec++; if (rx_valid !== 1'b1 || rx_data !== exp) begin errs++; $display("FAIL full_drain[%0d] got %b/%h exp 1/%h", i, rx_valid, rx_data, exp); end
      pulse_ready;
    end
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL full_empty got %b exp 0", rx_valid); end
  endtask
  task automatic test_reset_mid_frame;
    int lat;
    logic [9:0] f;
    send(8'h00, 1'b0, -1, -1, lat);
    rx = 1'b1;
    wait_clk(10);
    send(8'h11, 1'b1, -1, -1, lat);
    send(8'h22, 1'b1, -1, -1, lat);
    vec++; if (rx_count !== 5'd2 || frame_err !== 1'b1) begin errs++; $display("FAIL pre_reset got %0d/%b exp 2/1", rx_count, frame_err); end
    f = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 300; i++) begin
      rx = f[i/64];
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    vec++; if (rx_valid !== 1'b0) begin errs++; $display("FAIL midreset_valid got %b exp 0", rx_valid); end
    vec++; if (rx_count !== 5'd0) begin errs++; $display("FAIL midreset_count got %0d exp 0", rx_count); end
    vec++; if ({overrun, frame_err} !== 2'b00) begin errs++; $display("FAIL midreset_flags got %b exp 00", {overrun, frame_err}); end
    rx = 1'b1;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(5);
    send(8'h81, 1'b1, -1, -1, lat);
    vec++; if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin errs++; $display("FAIL after_reset_data got %b/%h exp 1/81", rx_valid, rx_data); end
    vec++; if (rx_count !== 5'd1) begin errs++; $display("FAIL after_reset_count got %0d exp 1", rx_count); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_burst_overrun;
    test_err_clr;
    test_glitch;
    test_frame_err;
    test_break;
    test_full_pop_collision;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
